// File: rtl/imem_boot_loader.sv
// Framed byte-stream program loader: assembles little-endian words into instruction memory
// and holds the core in reset until a checksum-verified image has been written.
module imem_boot_loader #(
   parameter logic [31:0] IMEM_BASE      = 32'h0,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rx_valid_i,
   input  logic [7:0]  rx_data_i,
   output logic        rx_ready_o,
   output logic        imem_wr_en_o,
   output logic [31:0] imem_wr_addr_o,
   output logic [31:0] imem_wr_data_o,
   output logic        core_reset_n_o,
   output logic        boot_done_o,
   output logic [1:0]  err_code_o
);

   localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ErrNone = 2'd0;
   localparam logic [1:0] ErrLen  = 2'd1;
   localparam logic [1:0] ErrCsum = 2'd2;
   localparam logic [1:0] ErrTmo  = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StLen0,
      StLen1,
      StData,
      StCsum,
      StDone,
      StError
   } state_e;

   state_e          state_q, state_d;
   logic [15:0]     len_q, len_d;
   logic [15:0]     word_idx_q, word_idx_d;
   logic [1:0]      byte_cnt_q, byte_cnt_d;
   logic [23:0]     wbuf_q, wbuf_d;
   logic [7:0]      csum_q, csum_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
   logic [1:0]      err_q, err_d;
   logic            rx_ready_q, rx_ready_d;
   logic            wr_en_q, wr_en_d;
   logic [31:0]     wr_addr_q, wr_addr_d;
   logic [31:0]     wr_data_q, wr_data_d;
   logic            core_rst_n_q, core_rst_n_d;
   logic            boot_done_q, boot_done_d;

   logic            accept;
   logic            tmo_active;
   logic [15:0]     len_new;

   assign accept     = rx_valid_i && rx_ready_q;
   assign tmo_active = (state_q == StLen0) || (state_q == StLen1) ||
                       (state_q == StData) || (state_q == StCsum);
   assign len_new    = {rx_data_i, len_q[7:0]};

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      word_idx_d = word_idx_q;
      byte_cnt_d = byte_cnt_q;
      wbuf_d     = wbuf_q;
      csum_d     = csum_q;
      tmo_d      = '0;
      err_d      = err_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      unique case (state_q)
         StIdle: begin
            if (accept && (rx_data_i == MAGIC)) begin
               state_d = StLen0;
            end
         end
         StLen0: begin
            if (accept) begin
               len_d[7:0] = rx_data_i;
               state_d    = StLen1;
            end
         end
         StLen1: begin
            if (accept) begin
               len_d = len_new;
               if ((len_new == 16'd0) || (32'(len_new) > MAX_WORDS)) begin
                  err_d   = ErrLen;
                  state_d = StError;
               end else begin
                  word_idx_d = '0;
                  byte_cnt_d = '0;
                  csum_d     = '0;
                  state_d    = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               csum_d     = csum_q ^ rx_data_i;
               byte_cnt_d = byte_cnt_q + 2'd1;
               unique case (byte_cnt_q)
                  2'd0: wbuf_d[7:0]   = rx_data_i;
                  2'd1: wbuf_d[15:8]  = rx_data_i;
                  2'd2: wbuf_d[23:16] = rx_data_i;
                  2'd3: begin
                     // Fourth byte completes the word; strobe goes out next cycle.
                     wr_en_d    = 1'b1;
                     wr_addr_d  = IMEM_BASE + {14'd0, word_idx_q, 2'b00};
                     wr_data_d  = {rx_data_i, wbuf_q};
                     word_idx_d = word_idx_q + 16'd1;
                     if (word_idx_q == (len_q - 16'd1)) begin
                        state_d = StCsum;
                     end
                  end
                  default: ;
               endcase
            end
         end
         StCsum: begin
            if (accept) begin
               if (rx_data_i == csum_q) begin
                  state_d = StDone;
               end else begin
                  err_d   = ErrCsum;
                  state_d = StError;
               end
            end
         end
         StDone: ;
         StError: begin
            if (accept && (rx_data_i == MAGIC)) begin
               err_d   = ErrNone;
               state_d = StLen0;
            end
         end
         default: state_d = StIdle;
      endcase

      // An accepted byte always wins over an expiring count.
      if (tmo_active && !accept) begin
         if (tmo_q == TmoLast) begin
            err_d   = ErrTmo;
            state_d = StError;
         end else begin
            tmo_d = tmo_q + TmoW'(1);
         end
      end

      rx_ready_d   = (state_d != StDone);
      core_rst_n_d = (state_d == StDone);
      boot_done_d  = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         len_q        <= '0;
         word_idx_q   <= '0;
         byte_cnt_q   <= '0;
         wbuf_q       <= '0;
         csum_q       <= '0;
         tmo_q        <= '0;
         err_q        <= ErrNone;
         rx_ready_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         core_rst_n_q <= 1'b0;
         boot_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         word_idx_q   <= word_idx_d;
         byte_cnt_q   <= byte_cnt_d;
         wbuf_q       <= wbuf_d;
         csum_q       <= csum_d;
         tmo_q        <= tmo_d;
         err_q        <= err_d;
         rx_ready_q   <= rx_ready_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         core_rst_n_q <= core_rst_n_d;
         boot_done_q  <= boot_done_d;
      end
   end

   assign rx_ready_o     = rx_ready_q;
   assign imem_wr_en_o   = wr_en_q;
   assign imem_wr_addr_o = wr_addr_q;
   assign imem_wr_data_o = wr_data_q;
   assign core_reset_n_o = core_rst_n_q;
   assign boot_done_o    = boot_done_q;
   assign err_code_o     = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frame vectors from a table plus hand-written
// timeout and mid-frame reset sequences; expected writes go through a scoreboard queue.
module tb_imem_boot_loader;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_ready_o;
   logic        imem_wr_en_o;
   logic [31:0] imem_wr_addr_o;
   logic [31:0] imem_wr_data_o;
   logic        core_reset_n_o;
   logic        boot_done_o;
   logic [1:0]  err_code_o;

   always #5 clk = ~clk;

   imem_boot_loader #(
      .IMEM_BASE      (32'h0),
      .MAX_WORDS      (1024),
      .MAGIC          (8'hA5),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rx_valid_i     (rx_valid_i),
      .rx_data_i      (rx_data_i),
      .rx_ready_o     (rx_ready_o),
      .imem_wr_en_o   (imem_wr_en_o),
      .imem_wr_addr_o (imem_wr_addr_o),
      .imem_wr_data_o (imem_wr_data_o),
      .core_reset_n_o (core_reset_n_o),
      .boot_done_o    (boot_done_o),
      .err_code_o     (err_code_o)
   );

   typedef struct packed {
      logic             rst;
      logic             rnd;
      logic [4:0]       n;
      logic [4:0]       first;
      logic [1:0]       nwr;
      logic [0:15][7:0] b;
      logic [0:1][31:0] wd;
      logic [1:0]       err;
      logic             done;
   } vec_t;

   // Data bytes 13 00 00 00 93 00 10 00 XOR to 0x90.
   localparam logic [127:0] FrNom   = 128'hA5020013000000930010009000000000;
   localparam logic [127:0] FrBad   = 128'hA5020013000000930010008100000000;
   localparam logic [127:0] FrLen0  = 128'hA5000000000000000000000000000000;
   localparam logic [127:0] FrLenHi = 128'hA5010400000000000000000000000000;
   localparam logic [127:0] FrNoise = 128'h00FF5AA5020013000000930010009000;

   int          n_chk = 0;
   int          n_err = 0;
   logic [63:0] exp_q[$];
   logic        due = 1'b0;
   vec_t        vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One cycle: check the strobe produced by the previous edge, then drive new inputs.
   task automatic step(input logic v, input logic [7:0] d, output logic acc);
      logic [63:0] w;
      @(negedge clk);
      if (imem_wr_en_o || due) begin
         chk("wr_strobe", 64'(imem_wr_en_o), 64'(due));
         if (due) begin
            w = exp_q.pop_front();
            if (imem_wr_en_o) chk("wr_addr_data", {imem_wr_addr_o, imem_wr_data_o}, w);
         end
      end
      due        = 1'b0;
      rx_valid_i = v;
      rx_data_i  = d;
      acc        = v && rx_ready_o;
   endtask

   task automatic idle(input int n);
      logic acc;
      repeat (n) step(1'b0, 8'h00, acc);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input int gaps);
      logic acc;
      int   tries;
      idle(gaps);
      acc   = 1'b0;
      tries = 0;
      while (!acc && tries < 20) begin
         step(1'b1, b, acc);
         tries++;
      end
      chk("byte_accepted", 64'(acc), 64'd1);
      if (acc && wr) begin
         exp_q.push_back({addr, data});
         due = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n    = 1'b0;
      rx_valid_i = 1'b0;
      due        = 1'b0;
      exp_q.delete();
      #1;
      chk("reset_ctrl", 64'({rx_ready_o, imem_wr_en_o, core_reset_n_o, boot_done_o, err_code_o}),
          64'd0);
      chk("reset_wr_bus", {imem_wr_addr_o, imem_wr_data_o}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("ready_first_cycle", 64'(rx_ready_o), 64'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic acc;
      for (int i = 0; i < int'(v.n); i++) begin
         int   di;
         int   k;
         logic wr;
         di = i - int'(v.first);
         k  = di / 4;
         wr = (di >= 0) && (di % 4 == 3) && (k < int'(v.nwr));
         send_byte(v.b[i], wr, 32'(4 * k), wr ? v.wd[k[0]] : 32'h0,
                   v.rnd ? int'($urandom_range(0, 2)) : 0);
      end
      idle(3);
      chk($sformatf("v%0d_err", idx), 64'(err_code_o), 64'(v.err));
      chk($sformatf("v%0d_done", idx), 64'(boot_done_o), 64'(v.done));
      chk($sformatf("v%0d_core_rst_n", idx), 64'(core_reset_n_o), 64'(v.done));
      chk($sformatf("v%0d_ready", idx), 64'(rx_ready_o), 64'(!v.done));
      chk($sformatf("v%0d_writes_seen", idx), 64'(exp_q.size()), 64'd0);
      if (v.done) begin
         repeat (3) begin
            step(1'b1, 8'hA5, acc);
            chk($sformatf("v%0d_done_no_accept", idx), 64'(acc), 64'd0);
         end
         idle(2);
      end
   endtask

   initial begin
      vec_t v;
      vecs[0] = '{rst: 1'b1, rnd: 1'b0, n: 5'd12, first: 5'd3, nwr: 2'd2, b: FrNom,
                  wd: {32'h00000013, 32'h00100093}, err: 2'd0, done: 1'b1};
      vecs[1] = '{rst: 1'b1, rnd: 1'b0, n: 5'd3, first: 5'd3, nwr: 2'd0, b: FrLen0,
                  wd: 64'd0, err: 2'd1, done: 1'b0};
      vecs[2] = '{rst: 1'b0, rnd: 1'b0, n: 5'd3, first: 5'd3, nwr: 2'd0, b: FrLenHi,
                  wd: 64'd0, err: 2'd1, done: 1'b0};
      vecs[3] = '{rst: 1'b1, rnd: 1'b0, n: 5'd12, first: 5'd3, nwr: 2'd2, b: FrBad,
                  wd: {32'h00000013, 32'h00100093}, err: 2'd2, done: 1'b0};
      vecs[4] = '{rst: 1'b0, rnd: 1'b0, n: 5'd12, first: 5'd3, nwr: 2'd2, b: FrNom,
                  wd: {32'h00000013, 32'h00100093}, err: 2'd0, done: 1'b1};
      vecs[5] = '{rst: 1'b1, rnd: 1'b1, n: 5'd15, first: 5'd6, nwr: 2'd2, b: FrNoise,
                  wd: {32'h00000013, 32'h00100093}, err: 2'd0, done: 1'b1};

      for (int i = 0; i < 6; i++) begin
         if (vecs[i].rst) do_reset();
         run_vec(vecs[i], i);
      end

      // Timeout: 16 idle cycles after a data byte expire the count.
      do_reset();
      send_byte(8'hA5, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h01, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h00, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h11, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h22, 1'b0, 32'h0, 32'h0, 0);
      idle(16);
      chk("tmo_not_yet", 64'(err_code_o), 64'd0);
      idle(1);
      chk("tmo_err", 64'(err_code_o), 64'd3);
      chk("tmo_core_held", 64'(core_reset_n_o), 64'd0);

      // A byte arriving on the last idle cycle beats the timeout.
      do_reset();
      send_byte(8'hA5, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h01, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h00, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h11, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h22, 1'b0, 32'h0, 32'h0, 0);
      idle(15);
      send_byte(8'h33, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h44, 1'b1, 32'h0, 32'h44332211, 0);
      idle(2);
      chk("tmo_byte_wins", 64'(err_code_o), 64'd0);
      send_byte(8'h44, 1'b0, 32'h0, 32'h0, 0);
      idle(2);
      chk("tmo_frame_done", 64'({boot_done_o, core_reset_n_o, err_code_o}), 64'b1100);

      // Reset after six data bytes: word 0 written, partial word 1 dropped.
      do_reset();
      send_byte(8'hA5, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h02, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h00, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h13, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h00, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h00, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h00, 1'b1, 32'h0, 32'h00000013, 0);
      send_byte(8'h93, 1'b0, 32'h0, 32'h0, 0);
      send_byte(8'h00, 1'b0, 32'h0, 32'h0, 0);
      do_reset();
      idle(3);
      v     = vecs[0];
      v.rst = 1'b0;
      run_vec(v, 9);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
